// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state, counter and
// grant-index widths, the debug view of the arbiter state, and a
// saturating counter helper.
package fifo_arb_pkg;

    localparam int CNT_W = 4;
    localparam int GID_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Snapshot of the internal arbiter state, exported for observation.
    typedef struct packed {
        arb_state_e       state;
        logic [GID_W-1:0] rr_ptr;
        logic [CNT_W-1:0] beat_cnt;
        logic [CNT_W-1:0] idle_cnt;
    } arb_dbg_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating-priority search: returns the first set bit of req at or after
// start, wrapping around, plus a flag saying whether any bit was set.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   start,
    output logic [GID_W-1:0]   winner,
    output logic               found
);

    // Walk offsets from farthest to nearest so the nearest requester is
    // the last write and therefore wins.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NUM_REQ;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (k == idx && req[k]) begin
                    found  = 1'b1;
                    winner = GID_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a shared FIFO write port.
// One producer holds the grant at a time; its beats go straight to the
// FIFO while fifo_full is low. The grant ends on a last beat, after
// BURST_MAX beats, or after IDLE_TO consecutive cycles without valid.
//
// Handshake: a beat transfers in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready only depends on the grant and
// fifo_full, never on req_valid. A producer holds data/last stable
// while valid is high and ready is low.
//
// Optional build macro FIFO_ARB_PRIO0_EN: producer 0 wins every
// arbitration it takes part in and its release leaves rr_ptr unchanged.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    parameter int IDLE_TO   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output arb_dbg_t                  dbg
);

    arb_state_e       state_q,    state_d;
    logic [GID_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic [GID_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    logic [GID_W-1:0] rr_winner;
    logic             rr_found;
    logic [GID_W-1:0] sel_winner;
    logic             gnt_valid;
    logic             gnt_last;
    logic [DATA_W-1:0] gnt_data;
    logic             accept;
    logic             release_gnt;
    logic [GID_W-1:0] rr_next;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .start  (rr_ptr_q),
        .winner (rr_winner),
        .found  (rr_found)
    );

`ifdef FIFO_ARB_PRIO0_EN
    assign sel_winner = req_valid[0] ? '0 : rr_winner;
`else
    assign sel_winner = rr_winner;
`endif

    // Select the granted producer's handshake and data lanes.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GID_W'(i)) begin
                gnt_valid = req_valid[i];
                gnt_last  = req_last[i];
                gnt_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign busy         = (state_q == BURST);
    assign accept       = busy & gnt_valid & ~fifo_full;
    assign fifo_wr_en   = accept;
    assign fifo_wr_data = busy ? gnt_data : '0;
    assign grant_id     = grant_id_q;
    assign rr_next      = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    assign dbg.state    = state_q;
    assign dbg.rr_ptr   = rr_ptr_q;
    assign dbg.beat_cnt = beat_cnt_q;
    assign dbg.idle_cnt = idle_cnt_q;

    // Only the granted producer sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = busy && (grant_id_q == GID_W'(i)) && !fifo_full;
        end
    end

    // Next-state logic: arbitration in IDLE, beat/idle counting and release in BURST.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        release_gnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d    = BURST;
                    grant_id_d = sel_winner;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            BURST: begin
                if (gnt_valid) begin
                    // A full FIFO with valid high is a pure stall: counters hold.
                    if (!fifo_full) begin
                        beat_cnt_d = sat_inc(beat_cnt_q);
                        idle_cnt_d = '0;
                        if (gnt_last || beat_cnt_d == CNT_W'(BURST_MAX)) begin
                            release_gnt = 1'b1;
                        end
                    end
                end else begin
                    idle_cnt_d = sat_inc(idle_cnt_q);
                    if (idle_cnt_d >= CNT_W'(IDLE_TO)) begin
                        release_gnt = 1'b1;
                    end
                end
                if (release_gnt) begin
                    state_d = IDLE;
`ifdef FIFO_ARB_PRIO0_EN
                    if (grant_id_q != '0) begin
                        rr_ptr_d = rr_next;
                    end
`else
                    rr_ptr_d = rr_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any grant in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: simple per-producer beat generators,
// an expected-write queue checked on every FIFO write, and per-test
// checks of grant order, write patterns and internal counters.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic [2:0]                grant_id;
    logic                      busy;
    arb_dbg_t                  dbg;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_MAX (4),
        .IDLE_TO   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .dbg          (dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // bookkeeping
    int                vec_cnt = 0;
    int                err_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [2:0]        glog[$];
    logic [31:0]       wr_log;
    logic              prev_busy = 1'b0;
    logic [NUM_REQ-1:0] acc;

    // producer models
    logic [7:0] p_base [NUM_REQ];
    logic [7:0] p_step [NUM_REQ];
    int         p_total[NUM_REQ];
    int         p_lastn[NUM_REQ];
    int         p_sent [NUM_REQ];
    bit         p_en   [NUM_REQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = p_en[i] && (p_sent[i] < p_total[i]);
            req_data[i*DATA_W +: DATA_W] = 8'(int'(p_base[i]) + int'(p_step[i]) * p_sent[i]);
            req_last[i] = (p_lastn[i] != 0) && (p_sent[i] + 1 == p_lastn[i]);
        end
    endtask

    task automatic set_prod(input int i, input logic [7:0] base, input logic [7:0] step,
                            input int total, input int lastn);
        p_base[i]  = base;
        p_step[i]  = step;
        p_total[i] = total;
        p_lastn[i] = lastn;
        p_sent[i]  = 0;
        p_en[i]    = 1'b1;
    endtask

    task automatic disable_all();
        for (int i = 0; i < NUM_REQ; i++) p_en[i] = 1'b0;
        drive_inputs();
    endtask

    // Sample mid-cycle: record handshakes, check writes against exp_q, log grants.
    task automatic settle();
        #1;
        acc = req_valid & req_ready;
        wr_log = {wr_log[30:0], fifo_wr_en};
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) check("wr_unexpected", {24'h0, fifo_wr_data}, 32'hFFFF_FFFF);
            else                   check("wr_data", {24'h0, fifo_wr_data}, {24'h0, exp_q.pop_front()});
        end
        if (busy && !prev_busy) glog.push_back(grant_id);
        prev_busy = busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) p_sent[i]++;
        drive_inputs();
    endtask

    task automatic run_cycle();
        settle();
        tick();
    endtask

    initial begin
        logic [2:0] eg[5];
        rst       = 1'b0;
        fifo_full = 1'b0;
        wr_log    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            p_en[i] = 1'b0; p_total[i] = 0; p_lastn[i] = 0; p_sent[i] = 0;
            p_base[i] = 8'h00; p_step[i] = 8'h00;
        end
        drive_inputs();

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy",     32'(busy), 0);
        check("rst_grant",    32'(grant_id), 0);
        check("rst_ready",    32'(req_ready), 0);
        check("rst_wr_en",    32'(fifo_wr_en), 0);
        check("rst_wr_data",  32'(fifo_wr_data), 0);
        check("rst_rr_ptr",   32'(dbg.rr_ptr), 0);
        check("rst_beat_cnt", 32'(dbg.beat_cnt), 0);
        check("rst_idle_cnt", 32'(dbg.idle_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // ---- all four requesting, long bursts: grants 0,1,2,3,0 ----
        for (int i = 0; i < NUM_REQ; i++) set_prod(i, 8'(i * 16 + 1), 8'h01, 8, (i == 0) ? 8 : 0);
        drive_inputs();
        for (int g = 0; g < 4; g++) for (int b = 1; b <= 4; b++) exp_q.push_back(8'(g * 16 + b));
        for (int b = 5; b <= 8; b++) exp_q.push_back(8'(b));
        glog.delete();
        wr_log = '0;
        repeat (25) run_cycle();
        disable_all();
        check("t2_wr_pattern", wr_log & 32'h01FF_FFFF, {7'h0, {5{5'b01111}}});
        eg = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        check("t2_grant_cnt", glog.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < glog.size()) check($sformatf("t2_grant%0d", k), 32'(glog[k]), 32'(eg[k]));
        end
        settle();
        check("t2_busy_after", 32'(busy), 0);
        check("t2_rr_after",   32'(dbg.rr_ptr), 1);
        tick();

        // ---- single producer 2: 0x11,0x22,0x33 ----
        set_prod(2, 8'h11, 8'h11, 3, 3);
        drive_inputs();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        glog.delete();
        wr_log = '0;
        repeat (5) run_cycle();
        disable_all();
        check("t1_wr_pattern", wr_log & 32'h1F, 32'b01110);
        check("t1_grant_cnt",  glog.size(), 1);
        if (glog.size() > 0) check("t1_grant", 32'(glog[0]), 2);
        check("t1_rr_after",   32'(dbg.rr_ptr), 3);

        // ---- fifo_full stall mid-burst on producer 3 ----
        set_prod(3, 8'h30, 8'h01, 4, 4);
        drive_inputs();
        for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'h30 + b));
        repeat (3) run_cycle();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t3_stall_wr_en", 32'(fifo_wr_en), 0);
            check("t3_stall_ready", 32'(req_ready), 0);
            check("t3_stall_busy",  32'(busy), 1);
            check("t3_stall_beat",  32'(dbg.beat_cnt), 2);
            check("t3_stall_idle",  32'(dbg.idle_cnt), 0);
            tick();
        end
        fifo_full = 1'b0;
        settle();
        check("t3_resume_beat",  32'(dbg.beat_cnt), 2);
        check("t3_resume_wr_en", 32'(fifo_wr_en), 1);
        check("t3_resume_grant", 32'(grant_id), 3);
        tick();
        repeat (2) run_cycle();
        disable_all();
        check("t3_busy_after", 32'(busy), 0);
        check("t3_rr_after",   32'(dbg.rr_ptr), 0);

        // ---- starvation guard: producer 1 goes quiet ----
        set_prod(1, 8'h40, 8'h01, 5, 0);
        drive_inputs();
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h50);
        repeat (2) run_cycle();
        p_en[1] = 1'b0;
        set_prod(2, 8'h50, 8'h01, 1, 1);
        drive_inputs();
        for (int k = 0; k < 8; k++) begin
            settle();
            check($sformatf("t4_idle_cnt%0d", k), 32'(dbg.idle_cnt), 32'(k));
            check("t4_hold_busy",  32'(busy), 1);
            check("t4_hold_grant", 32'(grant_id), 1);
            tick();
        end
        settle();
        check("t4_gap_busy", 32'(busy), 0);
        check("t4_gap_rr",   32'(dbg.rr_ptr), 2);
        tick();
        settle();
        check("t4_next_busy",  32'(busy), 1);
        check("t4_next_grant", 32'(grant_id), 2);
        tick();
        run_cycle();
        disable_all();
        check("t4_rr_after", 32'(dbg.rr_ptr), 3);

        // ---- reset mid-burst at beat 2 ----
        set_prod(3, 8'h60, 8'h01, 4, 4);
        drive_inputs();
        exp_q.push_back(8'h60); exp_q.push_back(8'h61);
        repeat (3) run_cycle();
        check("t5_pre_beat", 32'(dbg.beat_cnt), 2);
        rst = 1'b0;
        #1;
        check("t5_rst_busy",   32'(busy), 0);
        check("t5_rst_grant",  32'(grant_id), 0);
        check("t5_rst_ready",  32'(req_ready), 0);
        check("t5_rst_wr_en",  32'(fifo_wr_en), 0);
        check("t5_rst_data",   32'(fifo_wr_data), 0);
        check("t5_rst_rr",     32'(dbg.rr_ptr), 0);
        check("t5_rst_beat",   32'(dbg.beat_cnt), 0);
        check("t5_rst_state",  32'(dbg.state), 32'(IDLE));
        @(posedge clk); #1;
        rst = 1'b1;
        set_prod(0, 8'h70, 8'h01, 1, 1);
        drive_inputs();
        exp_q.push_back(8'h70); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
        glog.delete();
        repeat (6) run_cycle();
        disable_all();
        check("t5_grant_cnt", glog.size(), 2);
        if (glog.size() > 0) check("t5_grant0", 32'(glog[0]), 0);
        if (glog.size() > 1) check("t5_grant1", 32'(glog[1]), 3);
        check("t5_rr_after", 32'(dbg.rr_ptr), 0);

        // ---- requesters 0 and 3 with rr_ptr=3 ----
        set_prod(2, 8'h80, 8'h01, 1, 1);
        drive_inputs();
        exp_q.push_back(8'h80);
        glog.delete();
        repeat (3) run_cycle();
        check("t6_rr_setup", 32'(dbg.rr_ptr), 3);
        set_prod(0, 8'h90, 8'h01, 1, 1);
        set_prod(3, 8'hA0, 8'h01, 1, 1);
        drive_inputs();
`ifdef FIFO_ARB_PRIO0_EN
        exp_q.push_back(8'h90); exp_q.push_back(8'hA0);
        eg = '{3'd2, 3'd0, 3'd3, 3'd0, 3'd0};
`else
        exp_q.push_back(8'hA0); exp_q.push_back(8'h90);
        eg = '{3'd2, 3'd3, 3'd0, 3'd0, 3'd0};
`endif
        repeat (5) run_cycle();
        disable_all();
        check("t6_grant_cnt", glog.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < glog.size()) check($sformatf("t6_grant%0d", k), 32'(glog[k]), 32'(eg[k]));
        end

        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one 16-deep, 8-bit synchronous FIFO between several producers. Each producer offers bursts over a valid/ready handshake. The arbiter grants one producer at a time, forwards its beats onto the FIFO write port, and respects FIFO back-pressure. It sits directly in front of the FIFO write side; the read side is untouched.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 8, beat width; equals FIFO data width
- BURST_MAX, 4, maximum beats per grant (1..15)
- IDLE_TO, 8, consecutive idle cycles that cause a granted producer to lose its grant (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  producer i has a beat
- req_last  in  NUM_REQ  beat from producer i is the final beat of its burst
- req_data  in  NUM_REQ*DATA_W  beat data; producer i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  beat from producer i is accepted this cycle
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_W  FIFO write data
- grant_id  out  3  index of the granted producer; valid while busy=1
- busy  out  1  a grant is active

## Operation
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is high, pick the winner with the round-robin search starting at rr_ptr.
  - Latch the winner into grant_id, clear beat_cnt and idle_cnt, go to BURST.
  - No beat is accepted in IDLE.
- BURST:
  - accept = req_valid[grant_id] & ~fifo_full.
  - req_ready[grant_id] = ~fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = accept. fifo_wr_data = req_data slice of grant_id. Both are combinational.
  - On accept: beat_cnt += 1 and idle_cnt is cleared.
  - Grant release: the grant ends after an accepted beat with req_last=1, or after an accepted beat that makes beat_cnt equal BURST_MAX. On release, go to IDLE and set rr_ptr = grant_id+1 mod NUM_REQ.
  - Starvation guard: while req_valid[grant_id]=0 (fifo_full ignored), idle_cnt += 1. When idle_cnt reaches IDLE_TO, release the grant with the same rr_ptr update.
  - Full stall: fifo_full=1 with valid high does not accept a beat, does not increment idle_cnt, and never releases the grant.
- beat_cnt and idle_cnt are 4-bit and saturate. They cannot wrap, given the parameter ranges.
- Producers must hold req_data and req_last stable while req_valid=1 and ready=0.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0
  - beat_cnt=0, idle_cnt=0
  - req_ready=0, fifo_wr_en=0, fifo_wr_data=0
- Reset asserted mid-burst aborts the grant immediately. Partially written bursts stay in the FIFO.
- Arbitration latency: req_valid rising in IDLE leads to busy=1 and first possible accept on the next clk edge. Best case is a single-cycle gap.
- Grant turnaround: 1 IDLE cycle between consecutive grants. Peak throughput is BURST_MAX/(BURST_MAX+1).
- fifo_full is sampled combinationally in the same cycle. A beat is never written while fifo_full=1.
- req_last=1 and beat_cnt reaching BURST_MAX on the same beat cause a single release.

## Configuration
- FIFO_ARB_PRIO0_EN defined: in IDLE, req_valid[0]=1 always wins regardless of rr_ptr. rr_ptr is not updated when producer 0's grant is released. Other producers stay round-robin among themselves.
- Not defined: pure round-robin for all producers.

## Structure
- Shared package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST)
  - the counter width constant CNT_W=4
  - the grant index width constant GID_W=3
- One natural sub-module, fifo_arb_rr_pick: a combinational rotate-priority search (req vector, start pointer) producing winner index and found flag.

## Test plan
- Single producer: req 2 sends 3 beats (0x11,0x22,0x33 with last on 0x33) → grant_id=2, fifo_wr_en high for 3 cycles, rr_ptr=3 afterwards.
- All 4 requesting, long bursts, BURST_MAX=4 → grants go 0,1,2,3,0, with 4 beats each and one IDLE cycle between grants.
- fifo_full held high for 5 cycles mid-burst → no writes, req_ready=0, grant kept; the burst resumes with beat_cnt unchanged.
- Granted producer drops valid for 8 cycles (IDLE_TO=8) → release on the 8th idle cycle; the next requester is granted after 1 IDLE cycle.
- rst pulled low mid-burst at beat 2 → all outputs return to reset values asynchronously; after release, arbitration restarts at requester 0.
- With FIFO_ARB_PRIO0_EN, requesters 0 and 3 valid and rr_ptr=3 → requester 0 is granted first.
